// File: rtl/sys_out_accum.sv
// sys_out_accum: de-skews column psums from the array into a row buffer, accumulates
// cfg_passes K-tiles with saturation, then drains rows over a valid/ready stream.
module sys_out_accum #(
  parameter int SYS_COL = 16,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH = 40,
  parameter int DEPTH = 16,
  localparam int PSUM_WIDTH = 2 * DATA_WIDTH,
  localparam int RW = $clog2(DEPTH + 1),
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 start,
  input  logic [RW-1:0]                        cfg_rows,
  input  logic [7:0]                           cfg_passes,
  input  logic [SYS_COL-1:0]                   en_in,
  input  logic [SYS_COL-1:0][PSUM_WIDTH-1:0]   psum_in,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [SYS_COL-1:0][ACC_WIDTH-1:0]    out_data,
  output logic                                 out_last,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 err_drop
);
  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  state_t r_state, w_next;
  logic [RW-1:0] r_rows;
  logic [7:0] r_passes;
  logic [SYS_COL-1:0][AW-1:0] r_wptr;
  logic [SYS_COL-1:0][7:0] r_pass;
  logic [SYS_COL-1:0][ACC_WIDTH-1:0] r_buf [DEPTH];
  logic [SYS_COL-1:0][ACC_WIDTH-1:0] r_data, w_new;
  logic [SYS_COL-1:0] w_wr, w_wrap;
  logic [AW-1:0] r_rptr, w_idx;
  logic r_valid, r_last, r_done, r_err;
  logic w_start, w_hs, w_ld, w_drop;

  assign w_start = r_state == IDLE && start;
  assign w_hs = r_valid && out_ready;
  assign w_ld = r_state == DRAIN && (!r_valid || (out_ready && !r_last));
  assign w_idx = r_valid ? r_rptr + 1'b1 : '0;
  assign w_drop = r_state == COLLECT ? |(en_in & ~w_wr) : |en_in;

  for (genvar c = 0; c < SYS_COL; c++) begin : g_col
    logic [ACC_WIDTH-1:0] w_cur;
    logic [ACC_WIDTH:0] w_ext, w_sum;
    assign w_cur = r_buf[r_wptr[c]][c];
    assign w_ext = {{(ACC_WIDTH+1-PSUM_WIDTH){psum_in[c][PSUM_WIDTH-1]}}, psum_in[c]};
    assign w_sum = {w_cur[ACC_WIDTH-1], w_cur} + w_ext;
    assign w_wr[c] = r_state == COLLECT && en_in[c] && r_pass[c] < r_passes;
    assign w_wrap[c] = RW'(r_wptr[c]) == r_rows - RW'(1);
    assign w_new[c] = r_pass[c] == 8'd0 ? w_ext[ACC_WIDTH-1:0] :
                      w_sum[ACC_WIDTH] != w_sum[ACC_WIDTH-1] ? (w_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX) :
                      w_sum[ACC_WIDTH-1:0];
  end

  always_comb begin
    w_next = r_state;
    if (w_start) w_next = COLLECT;
    if (r_state == COLLECT && r_pass[SYS_COL-1] == r_passes) w_next = DRAIN;
    if (r_state == DRAIN && w_hs && r_last) w_next = IDLE;
  end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_state <= IDLE;
    else r_state <= w_next;

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_rows <= '0;
      r_passes <= '0;
      r_wptr <= '0;
      r_pass <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= (w_start ? 1'b0 : r_err) | w_drop;
      if (w_start) begin
        r_rows <= cfg_rows;
        r_passes <= cfg_passes;
        r_wptr <= '0;
        r_pass <= '0;
      end
      for (int c = 0; c < SYS_COL; c++)
        if (w_wr[c]) begin
          r_wptr[c] <= w_wrap[c] ? '0 : r_wptr[c] + 1'b1;
          if (w_wrap[c]) r_pass[c] <= r_pass[c] + 8'd1;
        end
    end

  always_ff @(posedge clk)
    for (int c = 0; c < SYS_COL; c++)
      if (w_wr[c]) r_buf[r_wptr[c]][c] <= w_new[c];

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_valid <= 1'b0;
      r_last <= 1'b0;
      r_done <= 1'b0;
      r_rptr <= '0;
      r_data <= '0;
    end else begin
      r_done <= r_state == DRAIN && w_hs && r_last;
      if (r_state != DRAIN || (w_hs && r_last)) begin
        r_valid <= 1'b0;
        r_last <= 1'b0;
      end else if (w_ld) begin
        r_valid <= 1'b1;
        r_rptr <= w_idx;
        r_data <= r_buf[w_idx];
        r_last <= RW'(w_idx) == r_rows - RW'(1);
      end
    end

  assign out_valid = r_valid;
  assign out_data = r_data;
  assign out_last = r_last;
  assign busy = r_state != IDLE;
  assign done = r_done;
  assign err_drop = r_err;
endmodule

// File: tb/tb_sys_out_accum.sv
// tb_sys_out_accum: table of tiles driven with column skew; drained rows are checked
// against an accumulate/saturate model through a row scoreboard.
module tb_sys_out_accum;
  localparam int SC = 4, DW = 16, AW = 33, DP = 4, PW = 32;
  localparam longint AMAX = (longint'(1) << 32) - 1;
  localparam longint AMIN = -(longint'(1) << 32);

  logic clk = 0, rstn = 0, start = 0, out_ready = 0;
  logic [2:0] cfg_rows = '0;
  logic [7:0] cfg_passes = '0;
  logic [SC-1:0] en_in = '0;
  logic [SC-1:0][PW-1:0] psum_in = '0;
  logic out_valid, out_last, busy, done, err_drop;
  logic [SC-1:0][AW-1:0] out_data;

  typedef struct {int rows; int passes; int mode; logic [3:0] rdy; bit extra; bit exp_err;} vec_t;
  typedef struct {logic [SC-1:0][AW-1:0] data; bit last;} row_t;
  row_t q[$];
  vec_t vecs[6];
  logic [PW-1:0] stim [4][DP][SC];
  int n_tests = 0, n_fail = 0, hs_cnt = 0, done_cnt = 0;
  string cur = "reset";
  logic pv = 0, pr = 0;
  logic [SC-1:0][AW-1:0] pdata = '0;

  sys_out_accum #(.SYS_COL(SC), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .DEPTH(DP)) dut (
    .clk(clk), .rstn(rstn), .start(start), .cfg_rows(cfg_rows), .cfg_passes(cfg_passes),
    .en_in(en_in), .psum_in(psum_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done), .err_drop(err_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0h expected %0h", cur, name, act, exp);
    end
  endtask

  function automatic longint sat(input longint v);
    return v > AMAX ? AMAX : (v < AMIN ? AMIN : v);
  endfunction

  always @(negedge clk) begin : mon
    row_t e;
    if (pv && !pr) begin
      chk("stall_valid", out_valid, 1);
      for (int c = 0; c < SC; c++) chk("stall_data", out_data[c], pdata[c]);
    end
    if (out_valid && out_ready) begin
      hs_cnt++;
      chk("row_available", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("last", out_last, e.last);
        for (int c = 0; c < SC; c++) chk("data", out_data[c], e.data[c]);
      end
    end
    if (done) done_cnt++;
    pv = out_valid;
    pr = out_ready;
    pdata = out_data;
  end

  task automatic prep(input vec_t v);
    longint acc, s;
    row_t r;
    for (int p = 0; p < v.passes; p++)
      for (int rr = 0; rr < v.rows; rr++)
        for (int c = 0; c < SC; c++)
          stim[p][rr][c] = v.mode == 0 ? PW'(rr * 10 + c) : v.mode == 1 ? 32'd5 :
                           v.mode == 2 ? 32'h7FFF_FFFF : v.mode == 3 ? 32'h8000_0000 : $urandom;
    for (int rr = 0; rr < v.rows; rr++) begin
      r.last = rr == v.rows - 1;
      for (int c = 0; c < SC; c++) begin
        acc = 0;
        for (int p = 0; p < v.passes; p++) begin
          s = longint'(signed'(stim[p][rr][c]));
          acc = p == 0 ? s : sat(acc + s);
        end
        r.data[c] = AW'(acc);
      end
      q.push_back(r);
    end
  endtask

  task automatic begin_tile(input vec_t v);
    cfg_rows = 3'(v.rows);
    cfg_passes = 8'(v.passes);
    start = 1;
    @(posedge clk); #1;
    cfg_rows = 3'd1;
    cfg_passes = 8'd9;
    chk("busy_after_start", busy, 1);
    chk("err_cleared_on_start", err_drop, 0);
  endtask

  task automatic drive(input vec_t v, input int stop);
    for (int t = 0; t < stop; t++) begin
      for (int c = 0; c < SC; c++) begin
        int k;
        k = t - c;
        en_in[c] = k >= 0 && k < v.passes * v.rows;
        if (en_in[c]) psum_in[c] = stim[k / v.rows][k % v.rows][c];
        else psum_in[c] = '0;
      end
      if (v.extra && t == v.passes * v.rows) begin
        en_in[0] = 1'b1;
        psum_in[0] = 32'd12345;
      end
      @(posedge clk); #1;
    end
    en_in = '0;
    psum_in = '0;
  endtask

  task automatic run_tile(input vec_t v);
    bit got;
    got = 0;
    hs_cnt = 0;
    done_cnt = 0;
    q.delete();
    prep(v);
    begin_tile(v);
    drive(v, v.passes * v.rows + SC - 1);
    start = 0;
    chk("lat_e0", out_valid, 0);
    @(posedge clk); #1;
    chk("lat_e1", out_valid, 0);
    chk("busy_lat", busy, 1);
    @(posedge clk); #1;
    chk("lat_e2", out_valid, 1);
    chk("err_drop", err_drop, v.exp_err);
    for (int i = 0; i < 40; i++) begin
      out_ready = v.rdy[i % 4];
      @(posedge clk); #1;
      if (done) begin
        got = 1;
        break;
      end
    end
    out_ready = 0;
    chk("done_seen", got, 1);
    @(posedge clk); #1;
    chk("done_pulse_width", done, 0);
    chk("busy_end", busy, 0);
    chk("done_count", done_cnt, 1);
    chk("handshakes", hs_cnt, v.rows);
    chk("queue_empty", q.size(), 0);
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{4, 1, 0, 4'b1111, 0, 0};
    vecs[1] = '{2, 3, 1, 4'b1111, 0, 0};
    vecs[2] = '{4, 4, 2, 4'b1111, 0, 0};
    vecs[3] = '{3, 4, 3, 4'b0101, 0, 0};
    vecs[4] = '{4, 2, 4, 4'b0101, 0, 0};
    vecs[5] = '{1, 2, 0, 4'b0101, 1, 1};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_drop, 0);
    chk("rst_last", out_last, 0);
    chk("rst_data", out_data[0], 0);
    rstn = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      cur = $sformatf("vec%0d", i);
      run_tile(vecs[i]);
    end
    cur = "idle_drop";
    en_in = 4'b0010;
    @(posedge clk); #1;
    en_in = '0;
    chk("err_set", err_drop, 1);
    chk("stays_idle", busy, 0);
    cur = "vec5";
    run_tile(vecs[5]);
    cur = "reset_mid";
    v = '{3, 2, 4, 4'b1111, 0, 0};
    done_cnt = 0;
    q.delete();
    prep(v);
    q.delete();
    begin_tile(v);
    drive(v, v.rows + 2);
    start = 0;
    chk("busy_before_reset", busy, 1);
    rstn = 0;
    #1;
    chk("valid", out_valid, 0);
    chk("busy", busy, 0);
    chk("done", done, 0);
    chk("err", err_drop, 0);
    chk("last", out_last, 0);
    for (int c = 0; c < SC; c++) chk("data", out_data[c], 0);
    @(posedge clk); #1;
    rstn = 1;
    @(posedge clk); #1;
    chk("no_done_pulse", done_cnt, 0);
    cur = "after_reset";
    run_tile(vecs[4]);
    cur = "redirty";
    run_tile(vecs[1]);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
